varredor_de_registradores: RTL and testbench



---
 rtl/varredor_de_registradores.sv | 171 +++++++++++++++++
 tb/tb_varredor_de_registradores.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/varredor_de_registradores.sv
// Purpose: drives the register bank's display select and shows the returned word as eight active-low 7-segment hex digits.
// Latency: outputs (hex, idx, valido pulse) update on the 3rd rising edge after entering SELECIONA.
// Backpressure: none; the bank answers combinationally, pausa freezes the dwell in automatic mode.
`timescale 1ns/1ps

module varredor_de_registradores #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic        vr_in_clk,
  input  logic        vr_in_rst_n,
  input  logic        vr_in_modo,
  input  logic        vr_in_pausa,
  input  logic [4:0]  vr_in_SW,
  output logic [4:0]  vr_out_sel,
  input  logic [31:0] vr_in_dado,
  output logic [4:0]  vr_out_idx,
  output logic [55:0] vr_out_hex,
  output logic        vr_out_valido
);

  typedef enum logic [1:0] {
    SELECIONA = 2'd0,
    ESPERA    = 2'd1,
    CAPTURA   = 2'd2,
    EXIBE     = 2'd3
  } estado_t;

  // Last dwell count value; reaching it ends the current display period.
  localparam logic [CNT_W-1:0] CONT_FIM = CNT_W'(DWELL_CYCLES - 1);

  estado_t          estado, prox_estado;
  logic [CNT_W-1:0] cont, prox_cont;
  logic [CNT_W-1:0] cont_base;
  logic [4:0]       pendente, prox_pendente;
  logic             modo_ativo, prox_modo_ativo;
  logic [4:0]       alvo;

  // One hex nibble to active-low gfedcba segments.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Whole 32-bit word to eight digits, nibble 0 in the low 7 bits.
  function automatic logic [55:0] codifica(input logic [31:0] v);
    logic [55:0] h;
    h = '0;
    for (int i = 0; i < 8; i++) begin
      h[i*7 +: 7] = seg7(v[i*4 +: 4]);
    end
    return h;
  endfunction

  // Index loaded in SELECIONA. modo_ativo is the mode latched in EXIBE, so a
  // mode flip during a capture does not change the register being fetched.
  always_comb begin
    alvo = modo_ativo ? pendente : vr_in_SW;
  end

  // Next-state and dwell counter logic.
  always_comb begin
    prox_estado     = estado;
    prox_cont       = cont;
    prox_pendente   = pendente;
    prox_modo_ativo = modo_ativo;
    cont_base       = cont;

    case (estado)
      SELECIONA: begin
        prox_cont   = '0;
        prox_estado = ESPERA;
      end

      ESPERA: begin
        prox_estado = CAPTURA;
      end

      CAPTURA: begin
        prox_estado = EXIBE;
      end

      EXIBE: begin
        prox_modo_ativo = vr_in_modo;
        if (!vr_in_modo) begin
          // Manual: follow the switches, refresh the same register each dwell.
          if (vr_in_SW != vr_out_idx) begin
            prox_estado = SELECIONA;
          end else if (cont == CONT_FIM) begin
            prox_estado = SELECIONA;
          end else begin
            prox_cont = cont + CNT_W'(1);
          end
        end else begin
          // Entering automatic from manual starts a fresh dwell from this cycle.
          cont_base = modo_ativo ? cont : '0;
          if (vr_in_pausa) begin
            prox_cont = cont_base;
          end else if (cont_base == CONT_FIM) begin
            prox_pendente = vr_out_idx + 5'd1;
            prox_estado   = SELECIONA;
          end else begin
            prox_cont = cont_base + CNT_W'(1);
          end
        end
      end

      default: begin
        prox_estado = SELECIONA;
      end
    endcase
  end

  // State, dwell counter, pending auto index and latched mode.
  always_ff @(posedge vr_in_clk or negedge vr_in_rst_n) begin
    if (!vr_in_rst_n) begin
      estado     <= SELECIONA;
      cont       <= '0;
      pendente   <= '0;
      modo_ativo <= 1'b0;
    end else begin
      estado     <= prox_estado;
      cont       <= prox_cont;
      pendente   <= prox_pendente;
      modo_ativo <= prox_modo_ativo;
    end
  end

  // Bank select only moves in SELECIONA so the read path sees a stable index.
  always_ff @(posedge vr_in_clk or negedge vr_in_rst_n) begin
    if (!vr_in_rst_n) begin
      vr_out_sel <= '0;
    end else if (estado == SELECIONA) begin
      vr_out_sel <= alvo;
    end
  end

  // Capture the bank word, encode it and pulse valido alongside the update.
  always_ff @(posedge vr_in_clk or negedge vr_in_rst_n) begin
    if (!vr_in_rst_n) begin
      vr_out_hex    <= '1;
      vr_out_idx    <= '0;
      vr_out_valido <= 1'b0;
    end else begin
      vr_out_valido <= (estado == CAPTURA);
      if (estado == CAPTURA) begin
        vr_out_hex <= codifica(vr_in_dado);
        vr_out_idx <= vr_out_sel;
      end
    end
  end

endmodule

// File: tb/tb_varredor_de_registradores.sv
// Bench for varredor_de_registradores: bank model answers vr_out_sel combinationally,
// expected indices are queued at stimulus time and compared on each valido pulse,
// with independent encoding of the expected hex digits.
`timescale 1ns/1ps

module tb_varredor_de_registradores;

  localparam int DWELL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        modo = 1'b0;
  logic        pausa = 1'b0;
  logic [4:0]  sw = 5'd0;
  logic [4:0]  sel;
  logic [31:0] dado;
  logic [4:0]  idx;
  logic [55:0] hex;
  logic        valido;

  logic [31:0] banco [32];

  int checks = 0;
  int errors = 0;
  int ciclo = 0;
  int npulsos = 0;
  int ult = 0;
  int r = 0;
  int t_a = 0;
  int n0 = 0;

  logic [4:0] fila [$];
  logic [4:0] cur_exp = 5'd0;
  logic       valido_ant = 1'b0;

  assign dado = banco[sel];

  varredor_de_registradores #(
    .DWELL_CYCLES(DWELL),
    .CNT_W(4)
  ) dut (
    .vr_in_clk(clk),
    .vr_in_rst_n(rst_n),
    .vr_in_modo(modo),
    .vr_in_pausa(pausa),
    .vr_in_SW(sw),
    .vr_out_sel(sel),
    .vr_in_dado(dado),
    .vr_out_idx(idx),
    .vr_out_hex(hex),
    .vr_out_valido(valido)
  );

  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s obs=%0h esp=%0h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  function automatic logic [6:0] seg_esp(input logic [3:0] n);
    logic [6:0] tabela [16];
    tabela[0]  = 7'b1000000; tabela[1]  = 7'b1111001; tabela[2]  = 7'b0100100; tabela[3]  = 7'b0110000;
    tabela[4]  = 7'b0011001; tabela[5]  = 7'b0010010; tabela[6]  = 7'b0000010; tabela[7]  = 7'b1111000;
    tabela[8]  = 7'b0000000; tabela[9]  = 7'b0010000; tabela[10] = 7'b0001000; tabela[11] = 7'b0000011;
    tabela[12] = 7'b1000110; tabela[13] = 7'b0100001; tabela[14] = 7'b0000110; tabela[15] = 7'b0001110;
    return tabela[n];
  endfunction

  function automatic logic [55:0] hex_esp(input logic [31:0] v);
    logic [55:0] h;
    h = '0;
    for (int i = 0; i < 8; i++) h[i*7 +: 7] = seg_esp(v[i*4 +: 4]);
    return h;
  endfunction

  // Monitor: samples 1 time unit after each rising edge, scoreboard on valido.
  always begin
    @(posedge clk);
    #1;
    ciclo++;
    if (valido) begin
      npulsos++;
      ult = ciclo;
      if (fila.size() > 0) cur_exp = fila.pop_front();
      verifica("sb_idx", 64'(idx), 64'(cur_exp));
      verifica("sb_hex", 64'(hex), 64'(hex_esp(banco[cur_exp])));
      verifica("valido_unico", 64'(valido_ant), 64'(0));
    end
    valido_ant = valido;
  end

  // Stimulus steps land 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic espera_pulso(input int limite);
    int  base;
    bit  ok;
    base = npulsos;
    ok = 1'b0;
    for (int i = 0; i < limite && !ok; i++) begin
      tick(1);
      if (npulsos != base) ok = 1'b1;
    end
    verifica("timeout_pulso", 64'(ok), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=running esp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) banco[i] = $urandom;
    banco[5]  = 32'h1234_5678;
    banco[31] = 32'hDEAD_BEEF;
    banco[3]  = 32'h0000_0000;

    // Reset values.
    rst_n = 1'b0;
    tick(3);
    verifica("rst_hex", 64'(hex), 64'({56{1'b1}}));
    verifica("rst_sel", 64'(sel), 64'(0));
    verifica("rst_idx", 64'(idx), 64'(0));
    verifica("rst_valido", 64'(valido), 64'(0));

    // Release with SW=0, then SW=5 after the select is loaded: idx 0 first, then reselect.
    fila.push_back(5'd0);
    fila.push_back(5'd5);
    rst_n = 1'b1;
    r = ciclo;
    tick(1);
    sw = 5'd5;
    espera_pulso(10);
    verifica("lat_reset", 64'(ult - r), 64'(3));
    espera_pulso(10);
    verifica("idx5", 64'(idx), 64'(5));
    verifica("hex_12345678", 64'(hex), 64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}));

    // Manual switch change 5 -> 31.
    sw = 5'd31;
    r = ciclo;
    fila.push_back(5'd31);
    tick(1);
    verifica("sel_estavel", 64'(sel), 64'(5));
    tick(1);
    verifica("sel31", 64'(sel), 64'(31));
    espera_pulso(10);
    // One edge to enter SELECIONA plus three to the update.
    verifica("lat_sw", 64'(ult - r), 64'(4));
    verifica("dig7_d", 64'(hex[55:49]), 64'(7'b0100001));
    verifica("dig0_F", 64'(hex[6:0]), 64'(7'b0001110));

    // Automatic scan from 30, wrapping 31 -> 0.
    sw = 5'd30;
    fila.push_back(5'd30);
    espera_pulso(10);
    t_a = ult;
    modo = 1'b1;
    fila.push_back(5'd31);
    fila.push_back(5'd0);
    fila.push_back(5'd1);
    espera_pulso(2 * DWELL + 10);
    verifica("passo_30_31", 64'(ult - t_a), 64'(DWELL + 3));
    t_a = ult;
    espera_pulso(2 * DWELL + 10);
    verifica("passo_31_0", 64'(ult - t_a), 64'(DWELL + 3));
    verifica("wrap_idx0", 64'(idx), 64'(0));
    t_a = ult;
    espera_pulso(2 * DWELL + 10);
    verifica("passo_0_1", 64'(ult - t_a), 64'(DWELL + 3));

    // Pause 20 cycles after 3 dwell counts have elapsed.
    tick(3);
    pausa = 1'b1;
    n0 = npulsos;
    tick(20);
    verifica("pausa_sem_pulso", 64'(npulsos), 64'(n0));
    verifica("pausa_idx", 64'(idx), 64'(1));
    pausa = 1'b0;
    r = ciclo;
    fila.push_back(5'd2);
    espera_pulso(DWELL + 10);
    // Remaining dwell (DWELL-3) plus the three-cycle capture.
    verifica("pausa_resto", 64'(ult - r), 64'((DWELL - 3) + 3));

    // Back to manual on register 3, whose value then changes 0 -> 0xA.
    modo = 1'b0;
    sw = 5'd3;
    fila.push_back(5'd3);
    espera_pulso(10);
    verifica("hex_zero", 64'(hex), 64'({8{7'b1000000}}));
    banco[3] = 32'h0000_000A;
    r = ciclo;
    espera_pulso(DWELL + 6);
    verifica("refresh_prazo", 64'((ult - r) <= DWELL + 3), 64'(1));
    verifica("dig0_A", 64'(hex[6:0]), 64'(7'b0001000));
    verifica("dig7_1_zero", 64'(hex[55:7]), 64'({7{7'b1000000}}));

    // Asynchronous reset during ESPERA.
    sw = 5'd4;
    tick(2);
    rst_n = 1'b0;
    #1;
    verifica("arst_hex", 64'(hex), 64'({56{1'b1}}));
    verifica("arst_sel", 64'(sel), 64'(0));
    verifica("arst_idx", 64'(idx), 64'(0));
    verifica("arst_valido", 64'(valido), 64'(0));
    sw = 5'd0;
    tick(2);
    fila.push_back(5'd0);
    rst_n = 1'b1;
    r = ciclo;
    espera_pulso(10);
    verifica("lat_reset2", 64'(ult - r), 64'(3));
    verifica("fila_vazia", 64'(fila.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
